blake2_msg_sched: RTL and testbench

Message schedule stage for the BLAKE2 compression core. It accepts one 16-word message block, then emits the (x, y) word pair that each G invocation consumes: 8 G slots per round for ROUNDS rounds, in SIGMA-permuted order. It sits directly upstream of the G mixing function, and its output handshake paces the round datapath.

---
 rtl/blake2_pkg.sv | 32 +++
 rtl/blake2_sigma_sel.sv | 22 ++
 rtl/blake2_msg_sched.sv | 149 ++++++++++++++
 tb/tb_blake2_msg_sched.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blake2_pkg.sv
// Shared BLAKE2 constants: SIGMA permutation table, schedule FSM states and round counts.
package blake2_pkg;

    localparam int ROUNDS_S = 10;
    localparam int ROUNDS_B = 12;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // One row per SIGMA permutation; entry 0 sits in the most significant nibble.
    localparam logic [63:0] SIGMA [10] = '{
        64'h0123456789abcdef,
        64'hea489fd61c02b753,
        64'hb8c052fdae367194,
        64'h7931dcbe265a40f8,
        64'h905724afe1bc683d,
        64'h2c6a0b834d75fe19,
        64'hc51fed4a0763928b,
        64'hdb7ec13950f4862a,
        64'h6fe9b308c2d714a5,
        64'ha2847615fb9e3cd0
    };

    function automatic logic [3:0] sigma_idx(input logic [3:0] row, input logic [3:0] pos);
        logic [63:0] row_bits;
        row_bits = SIGMA[row];
        return row_bits[63 - 4 * pos -: 4];
    endfunction

endpackage

// File: rtl/blake2_sigma_sel.sv
// Combinational SIGMA lookup for one G slot: picks message words x and y out of the 16-word block.
module blake2_sigma_sel
    import blake2_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [3:0]      srow_i,
    input  logic [2:0]      g_i,
    input  logic [16*W-1:0] words_i,
    output logic [W-1:0]    x_o,
    output logic [W-1:0]    y_o
);

    logic [3:0] w_x_idx;
    logic [3:0] w_y_idx;

    assign w_x_idx = sigma_idx(srow_i, {g_i, 1'b0});
    assign w_y_idx = sigma_idx(srow_i, {g_i, 1'b1});
    assign x_o     = words_i[int'(w_x_idx) * W +: W];
    assign y_o     = words_i[int'(w_y_idx) * W +: W];

endmodule

// File: rtl/blake2_msg_sched.sv
// BLAKE2 message schedule: latches one block, then streams 8*ROUNDS SIGMA-ordered (x, y) pairs.
// Optional abort input is enabled by defining BLAKE2_MSG_SCHED_ABORT_EN.
module blake2_msg_sched
    import blake2_pkg::*;
#(
    parameter int W      = 32,
    parameter int ROUNDS = ROUNDS_S
) (
    input  logic            clk_i,
    input  logic            nreset_i,
    input  logic            m_valid_i,
    output logic            m_ready_o,
    input  logic [16*W-1:0] m_i,
`ifdef BLAKE2_MSG_SCHED_ABORT_EN
    input  logic            abort_i,
`endif
    output logic            valid_o,
    input  logic            ready_i,
    output logic [W-1:0]    x_o,
    output logic [W-1:0]    y_o,
    output logic [3:0]      round_o,
    output logic [2:0]      g_idx_o,
    output logic            last_o
);

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [16*W-1:0] r_words;
    logic [16*W-1:0] w_words_nxt;
    logic [3:0]      r_round;
    logic [3:0]      w_round_nxt;
    logic [3:0]      r_srow;
    logic [3:0]      w_srow_nxt;
    logic [2:0]      r_g;
    logic [2:0]      w_g_nxt;
    logic            r_valid;
    logic            w_valid_nxt;
    logic            r_last;
    logic            w_last_nxt;
    logic [W-1:0]    r_x;
    logic [W-1:0]    r_y;
    logic [W-1:0]    w_x;
    logic [W-1:0]    w_y;
    logic            w_abort;
    logic            w_adv;
    logic            w_final;

`ifdef BLAKE2_MSG_SCHED_ABORT_EN
    assign w_abort = abort_i & (r_state == RUN);
`else
    assign w_abort = 1'b0;
`endif

    assign w_adv   = r_valid & ready_i;
    assign w_final = (r_round == LAST_ROUND) && (r_g == 3'd7);

    // Next-state and counter logic; srow wraps 9 -> 0 explicitly instead of round modulo 10.
    always_comb begin
        w_state_nxt = r_state;
        w_words_nxt = r_words;
        w_round_nxt = r_round;
        w_srow_nxt  = r_srow;
        w_g_nxt     = r_g;
        w_valid_nxt = r_valid;
        case (r_state)
            IDLE: begin
                if (m_valid_i) begin
                    w_state_nxt = RUN;
                    w_words_nxt = m_i;
                    w_round_nxt = 4'd0;
                    w_srow_nxt  = 4'd0;
                    w_g_nxt     = 3'd0;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_valid_nxt = 1'b0;
                end
            end
            RUN: begin
                if (w_abort) begin
                    w_state_nxt = IDLE;
                    w_valid_nxt = 1'b0;
                end else if (w_adv && w_final) begin
                    w_state_nxt = IDLE;
                    w_valid_nxt = 1'b0;
                end else if (w_adv && (r_g == 3'd7)) begin
                    w_g_nxt     = 3'd0;
                    w_round_nxt = r_round + 4'd1;
                    w_srow_nxt  = (r_srow == 4'd9) ? 4'd0 : r_srow + 4'd1;
                end else if (w_adv) begin
                    w_g_nxt = r_g + 3'd1;
                end else begin
                    w_g_nxt = r_g;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
        w_last_nxt = w_valid_nxt && (w_round_nxt == LAST_ROUND) && (w_g_nxt == 3'd7);
    end

    // Word selection runs on next-state counters so x/y land in registers with their slot.
    blake2_sigma_sel #(
        .W (W)
    ) u_sigma_sel (
        .srow_i  (w_srow_nxt),
        .g_i     (w_g_nxt),
        .words_i (w_words_nxt),
        .x_o     (w_x),
        .y_o     (w_y)
    );

    // State, message block and registered output pair.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_state <= IDLE;
            r_words <= '0;
            r_round <= 4'd0;
            r_srow  <= 4'd0;
            r_g     <= 3'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_words <= w_words_nxt;
            r_round <= w_round_nxt;
            r_srow  <= w_srow_nxt;
            r_g     <= w_g_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_x     <= w_x;
            r_y     <= w_y;
        end
    end

    assign m_ready_o = (r_state == IDLE);
    assign valid_o   = r_valid;
    assign last_o    = r_last;
    assign x_o       = r_x;
    assign y_o       = r_y;
    assign round_o   = r_round;
    assign g_idx_o   = r_g;

endmodule

// File: tb/tb_blake2_msg_sched.sv
// Scoreboard bench for blake2_msg_sched: a BLAKE2s (W=32, 10 rounds) and a BLAKE2b (W=64, 12 rounds)
// instance share stimulus; expected pairs are queued at load and popped on each accepted pair.
module tb_blake2_msg_sched;

    localparam int RA = 10;
    localparam int RB = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nreset;
    logic m_valid;
    logic ready;
`ifdef BLAKE2_MSG_SCHED_ABORT_EN
    logic abort;
`endif
    logic [63:0]      wd [16];
    logic [16*32-1:0] m32;
    logic [16*64-1:0] m64;

    logic        a_m_ready, a_valid, a_last;
    logic [31:0] a_x, a_y;
    logic [3:0]  a_round;
    logic [2:0]  a_g;
    logic        b_m_ready, b_valid, b_last;
    logic [63:0] b_x, b_y;
    logic [3:0]  b_round;
    logic [2:0]  b_g;

    always_comb begin
        m32 = '0;
        m64 = '0;
        for (int k = 0; k < 16; k++) begin
            m32[k*32 +: 32] = wd[k][31:0];
            m64[k*64 +: 64] = wd[k];
        end
    end

    blake2_msg_sched #(.W(32), .ROUNDS(RA)) dut_a (
        .clk_i(clk), .nreset_i(nreset), .m_valid_i(m_valid), .m_ready_o(a_m_ready), .m_i(m32),
`ifdef BLAKE2_MSG_SCHED_ABORT_EN
        .abort_i(abort),
`endif
        .valid_o(a_valid), .ready_i(ready), .x_o(a_x), .y_o(a_y),
        .round_o(a_round), .g_idx_o(a_g), .last_o(a_last)
    );

    blake2_msg_sched #(.W(64), .ROUNDS(RB)) dut_b (
        .clk_i(clk), .nreset_i(nreset), .m_valid_i(m_valid), .m_ready_o(b_m_ready), .m_i(m64),
`ifdef BLAKE2_MSG_SCHED_ABORT_EN
        .abort_i(abort),
`endif
        .valid_o(b_valid), .ready_i(ready), .x_o(b_x), .y_o(b_y),
        .round_o(b_round), .g_idx_o(b_g), .last_o(b_last)
    );

    int sig [10][16] = '{
        '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
        '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
        '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
        '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
        '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
        '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
        '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
        '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
        '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
        '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
    };

    typedef struct {
        logic [63:0] x;
        logic [63:0] y;
        int          rnd;
        int          g;
        bit          last;
    } pair_t;

    pair_t qa [$];
    pair_t qb [$];
    bit    idle_a = 1'b0;
    bit    idle_b = 1'b0;
    int    n_chk  = 0;
    int    n_err  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cmp_pair(input string s, input pair_t p, input logic [63:0] x, input logic [63:0] y,
                            input int rnd, input int g, input bit last);
        chk({s, "_x"}, x, p.x);
        chk({s, "_y"}, y, p.y);
        chk({s, "_round"}, 64'(rnd), 64'(p.rnd));
        chk({s, "_g"}, 64'(g), 64'(p.g));
        chk({s, "_last"}, 64'(last), 64'(p.last));
    endtask

    // Expected stream: SIGMA row is round mod 10 for both instances.
    task automatic push_block();
        pair_t p;
        for (int r = 0; r < RB; r++) begin
            for (int g = 0; g < 8; g++) begin
                p.x    = wd[sig[r % 10][2*g]];
                p.y    = wd[sig[r % 10][2*g+1]];
                p.rnd  = r;
                p.g    = g;
                p.last = (r == RB - 1) && (g == 7);
                qb.push_back(p);
                if (r < RA) begin
                    p.x    = {32'h0, p.x[31:0]};
                    p.y    = {32'h0, p.y[31:0]};
                    p.last = (r == RA - 1) && (g == 7);
                    qa.push_back(p);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (nreset) begin
            if (idle_a) begin
                chk("a_idle_after_last_mready", a_m_ready, 1);
                chk("a_idle_after_last_valid", a_valid, 0);
                idle_a = 1'b0;
            end
            if (idle_b) begin
                chk("b_idle_after_last_mready", b_m_ready, 1);
                chk("b_idle_after_last_valid", b_valid, 0);
                idle_b = 1'b0;
            end
            if (a_valid) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_valid", a_valid, 0);
                end else begin
                    cmp_pair("a", qa[0], a_x, a_y, a_round, a_g, a_last);
                    if (ready) begin
                        if (qa[0].last) idle_a = 1'b1;
                        void'(qa.pop_front());
                    end
                end
            end
            if (b_valid) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_valid", b_valid, 0);
                end else begin
                    cmp_pair("b", qb[0], b_x, b_y, b_round, b_g, b_last);
                    if (ready) begin
                        if (qb[0].last) idle_b = 1'b1;
                        void'(qb.pop_front());
                    end
                end
            end
        end
    end

    // Called at posedge+1; leaves the caller at posedge+1 one cycle after acceptance.
    task automatic do_load();
        int t = 0;
        while (!(a_m_ready && b_m_ready) && t < 300) begin
            @(posedge clk); #1; t++;
        end
        chk("load_wait_ready", 64'(t < 300), 1);
        m_valid = 1'b1;
        push_block();
        @(posedge clk); #1;
        m_valid = 1'b0;
        chk("first_valid_a", a_valid, 1);
        chk("first_valid_b", b_valid, 1);
        chk("first_round_a", a_round, 0);
        chk("first_g_a", a_g, 0);
        chk("busy_mready_a", a_m_ready, 0);
    endtask

    task automatic drain(input bit rnd_ready);
        int t = 0;
        while ((qa.size() != 0 || qb.size() != 0) && t < 1000) begin
            @(posedge clk); #1; t++;
            ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        chk("drain_done", 64'(qa.size() + qb.size()), 0);
        ready = 1'b1;
    endtask

    task automatic wait_at(input int r, input int g);
        int t = 0;
        while (!(a_valid && a_round == 4'(r) && a_g == 3'(g)) && t < 500) begin
            @(posedge clk); #1; t++;
        end
        chk("wait_at_reached", 64'(t < 500), 1);
    endtask

    initial begin
        nreset  = 1'b0;
        m_valid = 1'b0;
        ready   = 1'b1;
`ifdef BLAKE2_MSG_SCHED_ABORT_EN
        abort   = 1'b0;
`endif
        for (int k = 0; k < 16; k++) wd[k] = 64'(k);
        #12;
        chk("rst_valid_a", a_valid, 0);
        chk("rst_mready_a", a_m_ready, 1);
        chk("rst_x_a", a_x, 0);
        chk("rst_y_a", a_y, 0);
        chk("rst_round_a", a_round, 0);
        chk("rst_g_a", a_g, 0);
        chk("rst_last_a", a_last, 0);
        chk("rst_valid_b", b_valid, 0);
        chk("rst_mready_b", b_m_ready, 1);
        @(negedge clk); nreset = 1'b1;
        @(posedge clk); #1;

        // Identity block, ready held high.
        do_load();
        drain(1'b0);

        // Random block with a 3-cycle stall at round 2 g 4, then an ignored load attempt.
        for (int k = 0; k < 16; k++) wd[k] = {$urandom, $urandom};
        do_load();
        wait_at(2, 4);
        ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_x_a", a_x, {32'h0, wd[sig[2][8]][31:0]});
            chk("stall_y_b", b_y, wd[sig[2][9]]);
            chk("stall_g_a", a_g, 4);
        end
        ready = 1'b1;
        for (int k = 0; k < 16; k++) wd[k] = {$urandom, $urandom};
        m_valid = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("run_mready_a", a_m_ready, 0);
        end
        m_valid = 1'b0;
        drain(1'b0);

        // Random backpressure over a whole block.
        do_load();
        drain(1'b1);

        // Reset in the middle of round 5.
        do_load();
        wait_at(5, 0);
        nreset = 1'b0;
        #1;
        chk("mid_rst_valid_a", a_valid, 0);
        chk("mid_rst_mready_a", a_m_ready, 1);
        chk("mid_rst_x_a", a_x, 0);
        chk("mid_rst_y_a", a_y, 0);
        chk("mid_rst_round_a", a_round, 0);
        chk("mid_rst_last_a", a_last, 0);
        chk("mid_rst_valid_b", b_valid, 0);
        chk("mid_rst_round_b", b_round, 0);
        qa.delete(); qb.delete();
        idle_a = 1'b0; idle_b = 1'b0;
        @(negedge clk); nreset = 1'b1;
        @(posedge clk); #1;
        do_load();
        drain(1'b0);

`ifdef BLAKE2_MSG_SCHED_ABORT_EN
        do_load();
        wait_at(3, 2);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_valid_a", a_valid, 0);
        chk("abort_last_a", a_last, 0);
        chk("abort_mready_a", a_m_ready, 1);
        chk("abort_mready_b", b_m_ready, 1);
        qa.delete(); qb.delete();
        for (int k = 0; k < 16; k++) wd[k] = {$urandom, $urandom};
        do_load();
        drain(1'b0);
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
